ay_a_tile_ctrl: RTL

//  Handshaked sequencer for the A^T.(x.w).A output-transform datapath.

---
 rtl/ay_a_tile_ctrl_pkg.sv | 13 +
 rtl/ay_a_tile_ctrl_wbank.sv | 32 +++
 rtl/ay_a_tile_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ay_a_tile_ctrl_pkg.sv
// Shared constants and result-phase encoding for the A^T.(x.w).A output-transform sequencer.
package ay_a_tile_ctrl_pkg;

    localparam int         AY_DW    = 32;
    localparam logic [1:0] COL_LAST = 2'd3;

    // A result is emitted when the column with this index is accepted.
    typedef enum logic [1:0] {
        RES_C0 = 2'd2,
        RES_C1 = 2'd3
    } res_phase_e;

endpackage

// File: rtl/ay_a_tile_ctrl_wbank.sv
// 4x4 transformed-weight bank: one column written per strobe, one column read combinationally.
module ay_a_wbank
    import ay_a_tile_ctrl_pkg::*;
#(
    parameter int DW = AY_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [1:0]           wcol_i,
    input  logic [3:0][DW-1:0]   wdata_i,
    input  logic [1:0]           rcol_i,
    output logic [3:0][DW-1:0]   rdata_o
);

    logic [3:0][3:0][DW-1:0] bank_q;
    logic [3:0][3:0][DW-1:0] bank_d;

    always_comb begin
        bank_d = bank_q;
        if (we_i) bank_d[wcol_i] = wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) bank_q <= '0;
        else      bank_q <= bank_d;
    end

    // Registered bank gives read-before-write for a same-cycle beat.
    assign rdata_o = bank_q[rcol_i];

endmodule

// File: rtl/ay_a_tile_ctrl.sv
// Handshaked A_y column sequencer: one input column per beat, two result columns per tile.
module ay_a_tile_ctrl
    import ay_a_tile_ctrl_pkg::*;
#(
    parameter int DW         = AY_DW,
    parameter int TILE_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_col,
    input  logic [DW-1:0]         cfg_w1,
    input  logic [DW-1:0]         cfg_w2,
    input  logic [DW-1:0]         cfg_w3,
    input  logic [DW-1:0]         cfg_w4,
    output logic                  cfg_ready,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_x1,
    input  logic [DW-1:0]         in_x2,
    input  logic [DW-1:0]         in_x3,
    input  logic [DW-1:0]         in_x4,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_res1,
    output logic [DW-1:0]         out_res2,
    output logic                  out_col,
    output logic                  out_last,
    output logic                  busy,
    output logic [TILE_CNT_W-1:0] tile_cnt
);

    logic [1:0]            col_cnt_q, col_cnt_d;
    logic [1:0][DW-1:0]    d1_q, d1_d, d2_q, d2_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_col_q, out_col_d;
    logic                  out_last_q, out_last_d;
    logic [DW-1:0]         res1_q, res1_d, res2_q, res2_d;
    logic [TILE_CNT_W-1:0] tile_cnt_q, tile_cnt_d;

    logic [3:0][DW-1:0]    x, w, p;
    logic [DW-1:0]         y1, y2;
    logic                  acc;

    assign x = {in_x4, in_x3, in_x2, in_x1};

    ay_a_wbank #(.DW(DW)) u_wbank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (cfg_we && cfg_ready && !flush),
        .wcol_i  (cfg_col),
        .wdata_i ({cfg_w4, cfg_w3, cfg_w2, cfg_w1}),
        .rcol_i  (col_cnt_q),
        .rdata_o (w)
    );

    // A_y column: products truncated to DW, all sums modulo 2^DW.
    always_comb begin
        for (int r = 0; r < 4; r++) p[r] = x[r] * w[r];
        y1 = p[0] + p[1] + p[2];
        y2 = p[1] - p[2] - p[3];
    end

    assign in_ready  = !flush && (!out_valid_q || out_ready);
    assign acc       = in_valid && in_ready;
    assign cfg_ready = (col_cnt_q == 2'd0);

    always_comb begin
        col_cnt_d   = col_cnt_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        out_valid_d = out_valid_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        res1_d      = res1_q;
        res2_d      = res2_q;
        tile_cnt_d  = tile_cnt_q;
        if (flush) begin
            col_cnt_d   = 2'd0;
            d1_d        = '0;
            d2_d        = '0;
            out_valid_d = 1'b0;
        end else begin
            if (acc) begin
                d2_d      = d1_q;
                d1_d      = {y2, y1};
                col_cnt_d = (col_cnt_q == COL_LAST) ? 2'd0 : col_cnt_q + 2'd1;
            end
            if (acc && col_cnt_q == RES_C0) begin
                out_valid_d = 1'b1;
                out_col_d   = 1'b0;
                out_last_d  = 1'b0;
                res1_d      = y1 + d1_q[0] + d2_q[0];
                res2_d      = y2 + d1_q[1] + d2_q[1];
            end else if (acc && col_cnt_q == RES_C1) begin
                out_valid_d = 1'b1;
                out_col_d   = 1'b1;
                out_last_d  = 1'b1;
                res1_d      = d2_q[0] - d1_q[0] - y1;
                res2_d      = d2_q[1] - d1_q[1] - y2;
                tile_cnt_d  = tile_cnt_q + TILE_CNT_W'(1);
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_cnt_q   <= 2'd0;
            d1_q        <= '0;
            d2_q        <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= 1'b0;
            out_last_q  <= 1'b0;
            res1_q      <= '0;
            res2_q      <= '0;
            tile_cnt_q  <= '0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            res1_q      <= res1_d;
            res2_q      <= res2_d;
            tile_cnt_q  <= tile_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign out_res1  = res1_q;
    assign out_res2  = res2_q;
    assign tile_cnt  = tile_cnt_q;
    assign busy      = (col_cnt_q != 2'd0) || out_valid_q;

endmodule
